// File: rtl/sha256_pkg.sv
// sha256_pkg: FIPS 180-4 constants, FSM state type and round helper functions.
// Latency: n/a (constants and pure combinational functions only).
// Backpressure: n/a.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Initial hash values, H0 in the most significant word.
  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  // Round constants; ascending packed range so K[0] is the first listed word.
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_schedule.sv
// sha256_w_schedule: message schedule as a 16-word sliding window; o_w is W[t] for the current round.
// Latency: loads the block on i_load, each i_shift advances one word (1 cycle).
// Backpressure: none; the window only moves when i_shift is high.
// Ports: clk, reset_n; i_load/i_block capture a new block; i_shift steps a round; o_w current W[t].
module sha256_w_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [511:0] i_block,
  output logic [31:0]  o_w
);

  // r_win[k] holds W[t+k]; index 0 maps to block[511:480].
  logic [0:15][31:0] r_win;
  logic [31:0]       w_new;

  // W[t+16] from the window: s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
  assign w_new = small_sigma1(r_win[14]) + r_win[9] + small_sigma0(r_win[1]) + r_win[0];
  assign o_w   = r_win[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win <= '0;
    end else if (i_load) begin
      r_win <= i_block;
    end else if (i_shift) begin
      r_win <= {r_win[1:15], w_new};
    end
  end

endmodule

// File: rtl/sha256_hash_core.sv
// sha256_hash_core: SHA-256 (and optionally SHA-224, macro SHA256_SHA224_EN) one-block compressor.
// Latency: 66 cycles from accepted init/next to ready=1 with digest_valid=1 (64 rounds + add + finish).
// Backpressure: init/next are only accepted while ready=1; commands while busy are dropped.
// Ports: clk, reset_n (async, active low); init/next/mode/block command; ready, digest, digest_valid.
module sha256_hash_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic         mode,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);

  state_t            r_state, w_state_nxt;
  logic              r_ready, r_valid;
  logic [5:0]        r_t;
  logic [0:7][31:0]  r_h;    // H0..H7
  logic [0:7][31:0]  r_wv;   // working variables a..h
  logic [0:7][31:0]  w_wv_nxt;
  logic [0:7][31:0]  w_h_sum;
  logic [255:0]      w_iv;
  logic [31:0]       w_w, w_t1, w_t2;
  logic              w_start, w_round;

`ifdef SHA256_SHA224_EN
  assign w_iv = mode ? IV_256 : IV_224;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_iv          = IV_256;
`endif

  sha256_w_schedule u_w_schedule (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_start),
    .i_shift (w_round),
    .i_block (block),
    .o_w     (w_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_round     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ready && (init || next)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ROUNDS;
        end
      end
      ST_ROUNDS: begin
        w_round = 1'b1;
        if (r_t == 6'd63) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // One FIPS round on a..h.
  always_comb begin
    w_t1 = r_wv[7] + big_sigma1(r_wv[4]) + ch(r_wv[4], r_wv[5], r_wv[6]) + K[r_t] + w_w;
    w_t2 = big_sigma0(r_wv[0]) + maj(r_wv[0], r_wv[1], r_wv[2]);
    w_wv_nxt = {w_t1 + w_t2, r_wv[0], r_wv[1], r_wv[2],
                r_wv[3] + w_t1, r_wv[4], r_wv[5], r_wv[6]};
    for (int i = 0; i < 8; i++) w_h_sum[i] = r_h[i] + r_wv[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_t     <= '0;
      r_h     <= '0;
      r_wv    <= '0;
    end else if (w_start) begin
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_t     <= '0;
      if (init) begin
        r_h  <= w_iv;
        r_wv <= w_iv;
      end else begin
        r_wv <= r_h;
      end
    end else if (w_round) begin
      r_t  <= r_t + 6'd1;
      r_wv <= w_wv_nxt;
    end else if (r_state == ST_DONE) begin
      r_h <= w_h_sum;
    end else if (!r_ready) begin
      // IDLE one cycle after DONE: H is final, announce it.
      r_ready <= 1'b1;
      r_valid <= 1'b1;
    end
  end

  assign ready        = r_ready;
  assign digest_valid = r_valid;
  assign digest       = r_h;

endmodule

// File: tb/tb_sha256_hash_core.sv
module tb_sha256_hash_core;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         init = 1'b0;
  logic         next = 1'b0;
  logic         mode = 1'b1;
  logic [511:0] block = '0;
  logic         ready;
  logic [255:0] digest;
  logic         digest_valid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_L1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_L2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] DG_ABC = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] DG_TWO = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [223:0] DG_224 = {
    32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
    32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7};

  sha256_hash_core dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .next         (next),
    .mode         (mode),
    .block        (block),
    .ready        (ready),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge; caller is #1 after a posedge with ready high.
  task automatic start_cmd(input logic c_init, input logic c_next, input logic c_mode,
                           input logic [511:0] blk, input string tag);
    init = c_init; next = c_next; mode = c_mode; block = blk;
    @(posedge clk); #1;
    init = 1'b0; next = 1'b0; block = {16{32'hdeadbeef}};
    chk({tag, " ready_low"}, 256'(ready), 256'(1'b0));
    chk({tag, " valid_low"}, 256'(digest_valid), 256'(1'b0));
  endtask

  // Wait for completion; checks digest shows H (chain value) mid-run and the 66-cycle latency.
  task automatic wait_done(input string tag, input logic [255:0] exp_h, input bit poke);
    int cyc = 0;
    while (!ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 20) chk({tag, " digest_mid"}, digest, exp_h);
      if (poke) begin
        if (cyc == 5)  begin init = 1'b1; block = BLK_L1; end
        if (cyc == 6)  init = 1'b0;
        if (cyc == 10) begin next = 1'b1; mode = 1'b0; block = BLK_L2; end
        if (cyc == 11) next = 1'b0;
      end
    end
    chk({tag, " latency"}, 256'(cyc), 256'(66));
    chk({tag, " valid_high"}, 256'(digest_valid), 256'(1'b1));
  endtask

  initial begin
    // 1: reset state, then idle with no command
    #12;
    chk("rst ready", 256'(ready), 256'(1'b1));
    chk("rst valid", 256'(digest_valid), 256'(1'b0));
    chk("rst digest", digest, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle ready", 256'(ready), 256'(1'b1));
    chk("idle digest", digest, '0);

    // 2: "abc", SHA-256
    start_cmd(1'b1, 1'b0, 1'b1, BLK_ABC, "abc");
    wait_done("abc", IV256, 1'b0);
    chk("abc digest", digest, DG_ABC);
    repeat (3) @(posedge clk);
    #1;
    chk("abc stable", digest, DG_ABC);

    // 3: two-block message; mode low on next must not matter
    start_cmd(1'b1, 1'b0, 1'b1, BLK_L1, "two1");
    wait_done("two1", IV256, 1'b0);
    start_cmd(1'b0, 1'b1, 1'b0, BLK_L2, "two2");
    wait_done("two2", digest, 1'b0);
    chk("two digest", digest, DG_TWO);

    // 4: mode=0 selects SHA-224 IV only when the option is built in
    start_cmd(1'b1, 1'b0, 1'b0, BLK_ABC, "m0");
`ifdef SHA256_SHA224_EN
    wait_done("m0", {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                     32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4}, 1'b0);
    chk("sha224 digest", 256'(digest[255:32]), 256'(DG_224));
`else
    wait_done("m0", IV256, 1'b0);
    chk("mode0 ignored", digest, DG_ABC);
`endif

    // 5: commands and block changes while busy are ignored
    start_cmd(1'b1, 1'b0, 1'b1, BLK_ABC, "busy");
    wait_done("busy", IV256, 1'b1);
    chk("busy digest", digest, DG_ABC);
    // chain the two-block result so that a "next" win would be visible
    start_cmd(1'b1, 1'b0, 1'b1, BLK_L1, "pre1");
    wait_done("pre1", IV256, 1'b0);
    start_cmd(1'b0, 1'b1, 1'b1, BLK_L2, "pre2");
    wait_done("pre2", digest, 1'b0);
    chk("pre digest", digest, DG_TWO);
    start_cmd(1'b1, 1'b1, 1'b1, BLK_ABC, "both");
    wait_done("both", IV256, 1'b0);
    chk("init wins", digest, DG_ABC);

    // 6: reset mid-run at round 30, then a fresh run
    start_cmd(1'b1, 1'b0, 1'b1, BLK_L1, "abort");
    repeat (30) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort ready", 256'(ready), 256'(1'b1));
    chk("abort valid", 256'(digest_valid), 256'(1'b0));
    chk("abort digest", digest, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort idle", 256'(ready), 256'(1'b1));
    start_cmd(1'b1, 1'b0, 1'b1, BLK_ABC, "fresh");
    wait_done("fresh", IV256, 1'b0);
    chk("fresh digest", digest, DG_ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
